// File: rtl/hwpe_dma_wr_router.sv
// HWPE DMA write router: decodes DMA writes into fmap1/fmap2/kmem SRAM ports
// through a small in-order FIFO, with per-region word counters and done flags.
module hwpe_dma_wr_router #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] FMEM1_BASE = 'h0000,
  parameter logic [ADDR_W-1:0] FMEM2_BASE = 'h1000,
  parameter logic [ADDR_W-1:0] KMEM_BASE  = 'h2000,
  parameter logic [ADDR_W-1:0] KMEM_END   = 'h4000,
  parameter int WA_W  = 10,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dma_wen,
  input  logic [ADDR_W-1:0] dma_wa,
  input  logic [63:0]       dma_wd,
  input  logic              clr,
  input  logic [15:0]       cfg_fmap_words,
  input  logic [15:0]       cfg_kmem_words,
  input  logic              fmap1_busy,
  input  logic              fmap2_busy,
  input  logic              kmem_busy,
  output logic              fmap1_we,
  output logic [WA_W-1:0]   fmap1_wa,
  output logic [63:0]       fmap1_wd,
  output logic              fmap2_we,
  output logic [WA_W-1:0]   fmap2_wa,
  output logic [63:0]       fmap2_wd,
  output logic              kmem_we,
  output logic [WA_W-1:0]   kmem_wa,
  output logic [63:0]       kmem_wd,
  output logic              fmap_done,
  output logic              kmem_done,
  output logic [2:0]        dma_err,
  output logic [2:0]        fifo_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = 2 + WA_W + 64;

  typedef enum logic [1:0] {
    R_F1 = 2'd0,
    R_F2 = 2'd1,
    R_K  = 2'd2
  } region_e;

  logic [EW-1:0]     mem [DEPTH];
  logic [PW-1:0]     wp, rp;
  logic [2:0]        level;
  region_e           sel;
  logic [ADDR_W-1:0] base;
  logic [WA_W-1:0]   word;
  logic              misal, oor, vld, full;
  logic              push, pop, ovf, hv;
  logic [1:0]        h_reg;
  logic [WA_W-1:0]   h_wa;
  logic [63:0]       h_wd;
  logic [15:0]       c1, c2, ck;
  logic [2:0]        err;

  always_comb begin
    sel  = R_F1;
    base = FMEM1_BASE;
    if (dma_wa >= KMEM_BASE) begin
      sel  = R_K;
      base = KMEM_BASE;
    end else if (dma_wa >= FMEM2_BASE) begin
      sel  = R_F2;
      base = FMEM2_BASE;
    end
  end

  assign word  = WA_W'((dma_wa - base) >> 3);
  assign misal = dma_wen && (dma_wa[2:0] != 3'd0);
  assign oor   = dma_wen && (dma_wa >= KMEM_END);
  assign vld   = dma_wen && !misal && !oor;
  assign full  = (level == 3'(DEPTH));

  assign h_reg = mem[rp][EW-1 -: 2];
  assign h_wa  = mem[rp][64 +: WA_W];
  assign h_wd  = mem[rp][63:0];
  assign hv    = (level != 3'd0);

  // Head-of-line blocking: a busy head region stalls everything behind it
  assign fmap1_we = hv && (h_reg == R_F1) && !fmap1_busy;
  assign fmap2_we = hv && (h_reg == R_F2) && !fmap2_busy;
  assign kmem_we  = hv && (h_reg == R_K)  && !kmem_busy;

  assign pop  = fmap1_we || fmap2_we || kmem_we;
  assign push = vld && (!full || pop);
  assign ovf  = vld && !push;

  assign fmap1_wa = h_wa;
  assign fmap2_wa = h_wa;
  assign kmem_wa  = h_wa;
  assign fmap1_wd = h_wd;
  assign fmap2_wd = h_wd;
  assign kmem_wd  = h_wd;

  assign fifo_level = level;
  assign dma_err    = err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= {sel, word, dma_wd};
        wp      <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 3'd1;
        2'b01:   level <= level - 3'd1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c1        <= '0;
      c2        <= '0;
      ck        <= '0;
      fmap_done <= 1'b0;
      kmem_done <= 1'b0;
      err       <= '0;
    end else if (clr) begin
      c1        <= '0;
      c2        <= '0;
      ck        <= '0;
      fmap_done <= 1'b0;
      kmem_done <= 1'b0;
      err       <= '0;
    end else begin
      if (fmap1_we && c1 != 16'hFFFF) c1 <= c1 + 16'd1;
      if (fmap2_we && c2 != 16'hFFFF) c2 <= c2 + 16'd1;
      if (kmem_we && ck != 16'hFFFF)  ck <= ck + 16'd1;
      fmap_done <= fmap_done || (cfg_fmap_words != 16'd0 &&
                   c1 >= cfg_fmap_words && c2 >= cfg_fmap_words);
      kmem_done <= kmem_done || (cfg_kmem_words != 16'd0 &&
                   ck >= cfg_kmem_words);
      err <= err | {ovf, oor, misal};
    end
  end

endmodule

// File: tb/tb_hwpe_dma_wr_router.sv
// Directed bench for hwpe_dma_wr_router: vector table for routing and
// address errors, hand sequences for stall/overflow, done flags and reset.
module tb_hwpe_dma_wr_router;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dma_wen = 1'b0;
  logic [15:0] dma_wa = '0;
  logic [63:0] dma_wd = '0;
  logic        clr = 1'b0;
  logic [15:0] cfg_fmap_words = '0;
  logic [15:0] cfg_kmem_words = '0;
  logic        fmap1_busy = 1'b0;
  logic        fmap2_busy = 1'b0;
  logic        kmem_busy = 1'b0;
  logic        fmap1_we, fmap2_we, kmem_we;
  logic [9:0]  fmap1_wa, fmap2_wa, kmem_wa;
  logic [63:0] fmap1_wd, fmap2_wd, kmem_wd;
  logic        fmap_done, kmem_done;
  logic [2:0]  dma_err, fifo_level;

  int n_chk = 0;
  int n_fail = 0;

  hwpe_dma_wr_router dut (
    .clk(clk), .rst(rst),
    .dma_wen(dma_wen), .dma_wa(dma_wa), .dma_wd(dma_wd),
    .clr(clr),
    .cfg_fmap_words(cfg_fmap_words), .cfg_kmem_words(cfg_kmem_words),
    .fmap1_busy(fmap1_busy), .fmap2_busy(fmap2_busy), .kmem_busy(kmem_busy),
    .fmap1_we(fmap1_we), .fmap1_wa(fmap1_wa), .fmap1_wd(fmap1_wd),
    .fmap2_we(fmap2_we), .fmap2_wa(fmap2_wa), .fmap2_wd(fmap2_wd),
    .kmem_we(kmem_we), .kmem_wa(kmem_wa), .kmem_wd(kmem_wd),
    .fmap_done(fmap_done), .kmem_done(kmem_done),
    .dma_err(dma_err), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [15:0] wa;
    logic [63:0] wd;
    logic        clr;
    logic [2:0]  busy;
    logic [2:0]  ewe;
    logic [9:0]  ewa;
    logic [63:0] ewd;
    logic [2:0]  elvl;
    logic [2:0]  eerr;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wen, input logic [15:0] wa,
                       input logic [63:0] wd, input logic [2:0] busy,
                       input logic c);
    @(negedge clk);
    dma_wen = wen;
    dma_wa  = wa;
    dma_wd  = wd;
    {kmem_busy, fmap2_busy, fmap1_busy} = busy;
    clr = c;
  endtask

  function automatic logic [9:0] act_wa();
    if (fmap1_we) return fmap1_wa;
    if (fmap2_we) return fmap2_wa;
    return kmem_wa;
  endfunction

  function automatic logic [63:0] act_wd();
    if (fmap1_we) return fmap1_wd;
    if (fmap2_we) return fmap2_wd;
    return kmem_wd;
  endfunction

  localparam logic [63:0] DA = 64'h1111_2222_3333_4444;
  localparam logic [63:0] DB = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] DC = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] DD = 64'hDEAD_BEEF_0000_0001;

  initial begin
    logic [9:0] seen[$];
    logic [9:0] exp_seq[5];

    tbl[0] = '{1'b1, 16'h0000, DA, 1'b0, 3'b000, 3'b000, 10'd0, 64'd0, 3'd0, 3'b000};
    tbl[1] = '{1'b1, 16'h1008, DB, 1'b0, 3'b000, 3'b001, 10'd0, DA, 3'd1, 3'b000};
    tbl[2] = '{1'b1, 16'h2010, DC, 1'b0, 3'b000, 3'b010, 10'd1, DB, 3'd1, 3'b000};
    tbl[3] = '{1'b0, 16'h0000, 64'd0, 1'b0, 3'b000, 3'b100, 10'd2, DC, 3'd1, 3'b000};
    tbl[4] = '{1'b0, 16'h0000, 64'd0, 1'b0, 3'b000, 3'b000, 10'd0, 64'd0, 3'd0, 3'b000};
    tbl[5] = '{1'b1, 16'h0003, DD, 1'b0, 3'b000, 3'b000, 10'd0, 64'd0, 3'd0, 3'b000};
    tbl[6] = '{1'b1, 16'h4000, DD, 1'b0, 3'b000, 3'b000, 10'd0, 64'd0, 3'd0, 3'b001};
    tbl[7] = '{1'b0, 16'h0000, 64'd0, 1'b0, 3'b000, 3'b000, 10'd0, 64'd0, 3'd0, 3'b011};
    tbl[8] = '{1'b0, 16'h0000, 64'd0, 1'b1, 3'b000, 3'b000, 10'd0, 64'd0, 3'd0, 3'b011};
    tbl[9] = '{1'b0, 16'h0000, 64'd0, 1'b0, 3'b000, 3'b000, 10'd0, 64'd0, 3'd0, 3'b000};

    // reset state
    #1;
    chk("rst_we", {kmem_we, fmap2_we, fmap1_we}, 3'b000);
    chk("rst_wa", {fmap1_wa, fmap2_wa, kmem_wa}, 30'd0);
    chk("rst_wd", fmap1_wd | fmap2_wd | kmem_wd, 64'd0);
    chk("rst_done", {fmap_done, kmem_done}, 2'b00);
    chk("rst_err", dma_err, 3'b000);
    chk("rst_lvl", fifo_level, 3'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // routing, bad addresses and clr via vector table
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].wen, tbl[i].wa, tbl[i].wd, tbl[i].busy, tbl[i].clr);
      #1;
      chk($sformatf("vec%0d_we", i), {kmem_we, fmap2_we, fmap1_we}, tbl[i].ewe);
      if (tbl[i].ewe != 3'b000) begin
        chk($sformatf("vec%0d_wa", i), act_wa(), tbl[i].ewa);
        chk($sformatf("vec%0d_wd", i), act_wd(), tbl[i].ewd);
      end
      chk($sformatf("vec%0d_lvl", i), fifo_level, tbl[i].elvl);
      chk($sformatf("vec%0d_err", i), dma_err, tbl[i].eerr);
    end

    // stall with overflow, then push at full with a same-cycle pop
    for (int k = 0; k < 6; k++)
      drive(1'b1, 16'h0100 + 16'(k * 8), 64'(k), 3'b001, 1'b0);
    drive(1'b0, 16'h0, 64'd0, 3'b001, 1'b0);
    #1;
    chk("stall_lvl", fifo_level, 3'd4);
    chk("stall_err", dma_err, 3'b100);
    chk("stall_we", {kmem_we, fmap2_we, fmap1_we}, 3'b000);
    drive(1'b0, 16'h0, 64'd0, 3'b001, 1'b1);
    drive(1'b1, 16'h0130, 64'h26, 3'b000, 1'b0);
    #1;
    chk("fullpop_we", fmap1_we, 1'b1);
    if (fmap1_we) seen.push_back(fmap1_wa);
    for (int k = 0; k < 9; k++) begin
      drive(1'b0, 16'h0, 64'd0, 3'b000, 1'b0);
      #1;
      if (k == 0) begin
        chk("fullpop_lvl", fifo_level, 3'd4);
        chk("fullpop_err", dma_err, 3'b000);
      end
      if (fmap1_we) seen.push_back(fmap1_wa);
    end
    exp_seq = '{10'h20, 10'h21, 10'h22, 10'h23, 10'h26};
    chk("drain_cnt", 64'(seen.size()), 64'd5);
    for (int k = 0; k < 5; k++)
      if (k < seen.size()) chk($sformatf("drain%0d_wa", k), seen[k], exp_seq[k]);
    chk("drain_lvl", fifo_level, 3'd0);

    // done flags
    drive(1'b0, 16'h0, 64'd0, 3'b000, 1'b1);
    cfg_fmap_words = 16'd25;
    cfg_kmem_words = 16'd576;
    for (int k = 0; k < 25; k++)
      drive(1'b1, 16'h0000 + 16'(k * 8), 64'(k), 3'b000, 1'b0);
    for (int k = 0; k < 25; k++)
      drive(1'b1, 16'h1000 + 16'(k * 8), 64'(k), 3'b000, 1'b0);
    drive(1'b0, 16'h0, 64'd0, 3'b000, 1'b0);
    drive(1'b0, 16'h0, 64'd0, 3'b000, 1'b0);
    #1;
    chk("fdone_early", fmap_done, 1'b0);
    drive(1'b0, 16'h0, 64'd0, 3'b000, 1'b0);
    #1;
    chk("fdone_rise", fmap_done, 1'b1);
    chk("kdone_early0", kmem_done, 1'b0);
    for (int k = 0; k < 576; k++)
      drive(1'b1, 16'h2000 + 16'(k * 8), 64'(k), 3'b000, 1'b0);
    drive(1'b0, 16'h0, 64'd0, 3'b000, 1'b0);
    drive(1'b0, 16'h0, 64'd0, 3'b000, 1'b0);
    #1;
    chk("kdone_early", kmem_done, 1'b0);
    drive(1'b0, 16'h0, 64'd0, 3'b000, 1'b0);
    #1;
    chk("kdone_rise", kmem_done, 1'b1);
    chk("fdone_hold", fmap_done, 1'b1);
    drive(1'b0, 16'h0, 64'd0, 3'b000, 1'b1);
    drive(1'b0, 16'h0, 64'd0, 3'b000, 1'b0);
    #1;
    chk("clr_done", {fmap_done, kmem_done}, 2'b00);
    drive(1'b0, 16'h0, 64'd0, 3'b000, 1'b0);
    drive(1'b0, 16'h0, 64'd0, 3'b000, 1'b0);
    #1;
    chk("clr_cnt", {fmap_done, kmem_done}, 2'b00);

    // reset mid-transfer
    for (int k = 0; k < 3; k++)
      drive(1'b1, 16'h0200 + 16'(k * 8), DD, 3'b001, 1'b0);
    drive(1'b0, 16'h0, 64'd0, 3'b001, 1'b0);
    #1;
    chk("mid_lvl", fifo_level, 3'd3);
    @(negedge clk);
    rst = 1'b1;
    fmap1_busy = 1'b0;
    #1;
    chk("mid_rst_lvl", fifo_level, 3'd0);
    chk("mid_rst_we", {kmem_we, fmap2_we, fmap1_we}, 3'b000);
    chk("mid_rst_wa", {fmap1_wa, fmap2_wa, kmem_wa}, 30'd0);
    chk("mid_rst_wd", fmap1_wd | fmap2_wd | kmem_wd, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 16'h2008, DC, 3'b000, 1'b0);
    drive(1'b0, 16'h0, 64'd0, 3'b000, 1'b0);
    #1;
    chk("post_we", {kmem_we, fmap2_we, fmap1_we}, 3'b100);
    chk("post_wa", kmem_wa, 10'd1);
    chk("post_wd", kmem_wd, DC);
    chk("post_lvl", fifo_level, 3'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hwpe_dma_wr_router.md
# hwpe_dma_wr_router

Receiving end of the HWPE DMA write port. Accepts 64-bit DMA writes (`dma_wen`/`dma_wa`/`dma_wd`) and decodes the byte address into one of three single-port SRAM regions: fmap bank 1, fmap bank 2 and kernel memory. Writes are buffered in a 4-entry in-order FIFO so that compute-side reads, which have priority on each SRAM port, never lose DMA data. The block also counts the words landed per region, raises load-complete flags for the instruction decoder, and flags malformed or lost writes.

## Interface
Parameters:
- `ADDR_W`, 16: DMA byte-address width (`HWPE_ADDR_WIDTH`).
- `FMEM1_BASE`, 16'h0000: fmap bank 1 base byte address.
- `FMEM2_BASE`, 16'h1000: fmap bank 2 base (`FMEM_ADDR2_START`).
- `KMEM_BASE`, 16'h2000: kernel memory base (`KMEM_ADDR_START`).
- `KMEM_END`, 16'h4000: exclusive upper bound of kernel memory.
- `WA_W`, 10: SRAM word-address width.
- `DEPTH`, 4: FIFO depth. Must be a power of 2.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `dma_wen` in 1: DMA write strobe, one 64-bit word per cycle.
- `dma_wa` in ADDR_W: DMA byte address, 8-byte aligned.
- `dma_wd` in 64: DMA write data; byte 0 is in [7:0].
- `clr` in 1: synchronous clear of counters, done flags and error flags. The FIFO is not cleared.
- `cfg_fmap_words` in 16: expected word count per fmap bank.
- `cfg_kmem_words` in 16: expected kernel word count.
- `fmap1_busy`, `fmap2_busy`, `kmem_busy` in 1: the compute side owns that SRAM port this cycle.
- `fmap1_we` out 1, `fmap1_wa` out WA_W, `fmap1_wd` out 64: fmap bank 1 write port.
- `fmap2_we` out 1, `fmap2_wa` out WA_W, `fmap2_wd` out 64: fmap bank 2 write port.
- `kmem_we` out 1, `kmem_wa` out WA_W, `kmem_wd` out 64: kernel SRAM write port.
- `fmap_done` out 1: sticky; both fmap bank counts have reached `cfg_fmap_words`.
- `kmem_done` out 1: sticky; kernel count has reached `cfg_kmem_words`.
- `dma_err` out 3: sticky error flags. {overflow, out_of_range, misaligned}.
- `fifo_level` out 3: current number of FIFO entries, 0..DEPTH.

## Operation
- **Decode on accept.** Region selection:
  - fmap1 when FMEM1_BASE ≤ wa < FMEM2_BASE.
  - fmap2 when FMEM2_BASE ≤ wa < KMEM_BASE.
  - kmem when KMEM_BASE ≤ wa < KMEM_END.
- **Word address.** Computed as (wa − base) >> 3, truncated to WA_W bits.
- **Stored entry.** Each FIFO entry holds {region[1:0], word addr, data}.
- **Misaligned writes.** If `dma_wa[2:0]` ≠ 0, the write is dropped and `dma_err[0]` is set.
- **Out-of-range writes.** If wa ≥ KMEM_END, the write is dropped and `dma_err[1]` is set.
- **Push rule.** A valid write is pushed when level < DEPTH, or when a pop occurs in the same cycle. Otherwise it is dropped and `dma_err[2]` is set.
- **Pop rule.** The head entry drives its region's port combinationally: `we` = head_valid & region match & ~busy. The head pops on that edge.
  - A busy region stalls the whole FIFO (strict in-order, head-of-line blocking).
  - Only one `*_we` is high per cycle.
- **Idle outputs.** `*_wa`/`*_wd` for a region whose `we` is low are don't-care. The implementation drives the head fields onto all three ports.
- **Counters.** One 16-bit counter per region, incremented on each `*_we`. Counters saturate at 16'hFFFF.
- **Done flags.**
  - `fmap_done` sets when cnt1 ≥ cfg_fmap_words, cnt2 ≥ cfg_fmap_words, and cfg_fmap_words ≠ 0.
  - `kmem_done` sets under the same rule using the kernel count and cfg_kmem_words.
  - Both stay set until `clr` or `rst`.
  - A cfg value of 0 disables the corresponding flag.
- **`clr` priority.** `clr` takes priority over same-cycle increments and error sets. The FIFO contents and in-flight pops proceed normally, but those pops are not counted.

## Timing
- **Reset values.** All `*_we` = 0, `*_wa` = 0, `*_wd` = 0, `fmap_done` = 0, `kmem_done` = 0, `dma_err` = 0, `fifo_level` = 0. The FIFO is empty.
- **Latency.** A write sampled at edge E0 can assert its `*_we` in the cycle after E0, so the SRAM captures it at E1. This gives 1 cycle latency when the port is not busy.
- **Throughput.** One word per cycle with no stall. Back-to-back DMA writes with no busy never exceed level 1.
- **Stalls.** Each busy cycle on the head's region adds one cycle. After DEPTH consecutive stalled pushes, further pushes overflow unless a pop happens in the same cycle.
- **Counter/flag timing.** Counters update at the edge where `*_we` is high. Done flags rise one edge after the counter reaches the threshold.
- **Reset mid-transfer.** Asserting `rst` empties the FIFO and forces all outputs to their reset values immediately. Pending entries are lost by design.
- **Pointer wrap.** FIFO pointers wrap modulo DEPTH.
- **Level accounting.** Simultaneous push and pop leaves `fifo_level` unchanged.

## Test plan
- **Basic routing.** Write wa = 0x0000, 0x1008, 0x2010 on back-to-back cycles with no busy. Expect `fmap1_we` wa=0, `fmap2_we` wa=1, `kmem_we` wa=2, each 1 cycle after its write, with data unchanged. `fifo_level` ≤ 1.
- **Stall and overflow.** Hold `fmap1_busy` = 1 and issue 6 writes to fmap1. Expect level to reach 4 and `dma_err` = 3'b100. Release busy: expect exactly 4 `fmap1_we` pulses, carrying the first 4 addresses in order.
- **Push at full with pop.** With level = 4, drop busy and push in the same cycle. Expect the push to be accepted, `dma_err[2]` to stay 0, and level to stay 4.
- **Bad addresses.** Write wa = 0x0003 and wa = 0x4000. Expect `dma_err` = 3'b011, no `*_we` pulses, and level 0.
- **Done flags.** Set cfg_fmap_words = 25 and cfg_kmem_words = 576. Load 25 words per fmap bank and 576 kernel words. Expect `fmap_done` to rise 1 edge after the 25th bank-2 write and `kmem_done` to rise after the 576th kernel write. A `clr` pulse returns both flags and all counters to 0.
- **Reset mid-transfer.** Assert `rst` while level = 3. Expect all outputs to read 0 in the same cycle. After release, a new write routes correctly with 1-cycle latency.
